// File: rtl/day1_feeder.sv
// ASCII decimal-line feeder: turns newline-separated numbers into par_input/next_val strobes.
// Optional FEEDER_CR_SKIP_EN: silently drop carriage returns so CRLF input parses like LF.
module day1_feeder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] par_input,
    output logic        next_val,
    output logic [15:0] value_count,
    output logic [15:0] group_count,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] accum_q, accum_d;
    logic [31:0] par_input_q, par_input_d;
    logic [15:0] value_count_q, value_count_d;
    logic [15:0] group_count_q, group_count_d;
    logic        digits_seen_q, digits_seen_d;
    logic        pend_zero_q, pend_zero_d;
    logic        eot_q, eot_d;
    logic        err_q, err_d;
    logic        accept;
    logic        is_digit;

    assign in_ready    = (state_q == S_IDLE) && !rst;
    assign next_val    = (state_q == S_PULSE);
    assign done        = (state_q == S_DONE);
    assign par_input   = par_input_q;
    assign value_count = value_count_q;
    assign group_count = group_count_q;
    assign err         = err_q;

    assign accept   = in_valid && in_ready;
    assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);

    always_comb begin
        state_d       = state_q;
        accum_d       = accum_q;
        par_input_d   = par_input_q;
        value_count_d = value_count_q;
        group_count_d = group_count_q;
        digits_seen_d = digits_seen_q;
        pend_zero_d   = pend_zero_q;
        eot_d         = eot_q;
        err_d         = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_digit) begin
                        accum_d       = (accum_q * 32'd10) + {28'd0, in_byte[3:0]};
                        digits_seen_d = 1'b1;
                    end else if (in_byte == 8'h0A) begin
                        par_input_d   = digits_seen_q ? accum_q : 32'd0;
                        accum_d       = 32'd0;
                        digits_seen_d = 1'b0;
                        state_d       = S_SETUP;
                    end else if (in_byte == 8'h04) begin
                        // A pending number is flushed first, then the closing zero follows.
                        par_input_d   = digits_seen_q ? accum_q : 32'd0;
                        pend_zero_d   = digits_seen_q;
                        eot_d         = 1'b1;
                        accum_d       = 32'd0;
                        digits_seen_d = 1'b0;
                        state_d       = S_SETUP;
`ifdef FEEDER_CR_SKIP_EN
                    end else if (in_byte == 8'h0D) begin
                        err_d = err_q;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETUP: state_d = S_PULSE;
            S_PULSE: begin
                value_count_d = value_count_q + 16'd1;
                if (par_input_q == 32'd0) begin
                    group_count_d = group_count_q + 16'd1;
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (pend_zero_q) begin
                    par_input_d = 32'd0;
                    pend_zero_d = 1'b0;
                    state_d     = S_SETUP;
                end else if (eot_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            accum_q       <= 32'd0;
            par_input_q   <= 32'd0;
            value_count_q <= 16'd0;
            group_count_q <= 16'd0;
            digits_seen_q <= 1'b0;
            pend_zero_q   <= 1'b0;
            eot_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            accum_q       <= accum_d;
            par_input_q   <= par_input_d;
            value_count_q <= value_count_d;
            group_count_q <= group_count_d;
            digits_seen_q <= digits_seen_d;
            pend_zero_q   <= pend_zero_d;
            eot_q         <= eot_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: doc/day1_feeder.md
DAY1_FEEDER -- requirements
Module: day1_feeder

Interface
REQ-001 Clock and reset SHALL be a single clock `clk` and a synchronous, active-high reset `rst`.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_byte  in  8  ASCII input character.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  feeder accepts in_byte this cycle.
- par_input  out  32  parsed value to the calorie-counter consumer.
- next_val  out  1  one-cycle strobe; the consumer samples par_input on its rising edge.
- value_count  out  16  strobes issued.
- group_count  out  16  zero (separator) strobes issued.
- done  out  1  EOT processed; the block is idle until reset.
- err  out  1  sticky flag: unexpected character seen.

Function
REQ-003 A byte SHALL be accepted on a clk edge where in_valid=1 and in_ready=1.
REQ-004 in_ready SHALL be 1 only in state IDLE with rst=0.
REQ-005 States SHALL be IDLE, SETUP, PULSE, HOLD and DONE.
REQ-006 Accepted digit 0x30-0x39 in IDLE: accum <= accum*10 + digit, modulo 2^32 (wrap, no flag); digits_seen <= 1; the block stays in IDLE.
REQ-007 Accepted 0x0A in IDLE: par_input <= (digits_seen ? accum : 0); accum <= 0; digits_seen <= 0; next state SETUP.
REQ-008 A blank line (0x0A with digits_seen=0) SHALL emit value 0; each consecutive 0x0A SHALL emit its own 0.
REQ-009 Accepted 0x04 (EOT) in IDLE with digits_seen=1: emit accum, then emit 0, then enter DONE.
REQ-010 Accepted 0x04 in IDLE with digits_seen=0: emit 0, then enter DONE.
REQ-011 A second queued emission SHALL be tracked by a pend_zero flag; HOLD SHALL go to SETUP when pend_zero=1, else to IDLE (or to DONE after EOT).
REQ-012 Emission sequence:
- SETUP: par_input stable, next_val=0.
- PULSE: next_val=1.
- HOLD: next_val=0, par_input still stable.
- Each of these states SHALL last exactly one cycle.
REQ-013 Latency: for 0x0A accepted at edge N, next_val SHALL be high during cycle N+2, and in_ready SHALL return to 1 in cycle N+4.
REQ-014 par_input SHALL hold the last emitted value until the next SETUP.
REQ-015 value_count SHALL increment on every PULSE; group_count SHALL increment on PULSE when par_input=0; both SHALL wrap 0xFFFF->0x0000.
REQ-016 Any other accepted byte in IDLE SHALL be discarded without changing accum, and SHALL set err.
REQ-017 DONE SHALL hold in_ready=0, next_val=0 and done=1 until reset; in_valid SHALL be ignored.

Reset
REQ-018 rst=1 at a clk edge SHALL force:
- state=IDLE.
- par_input=0, next_val=0, value_count=0, group_count=0, done=0, err=0.
- accum=0, digits_seen=0, pend_zero=0.
REQ-019 Reset SHALL override any state, including PULSE: next_val SHALL be 0 from the edge where rst is sampled, and no partial emission SHALL resume.
REQ-020 in_ready SHALL be 0 while rst=1, and 1 in the first cycle after rst is released.

Configuration
REQ-021 With FEEDER_CR_SKIP_EN defined, an accepted 0x0D in IDLE SHALL be silently discarded, leaving err unchanged, so CRLF files parse identically to LF files.
REQ-022 Without FEEDER_CR_SKIP_EN, 0x0D SHALL be treated per REQ-016 (discarded, err set).

Verification
REQ-023 "1000\n2000\n\n4000\n" then 0x04:
- strobes par_input = 1000, 2000, 0, 4000, 0.
- value_count=5, group_count=2, done=1, err=0.
REQ-024 Timing: "7\n" with in_valid held high:
- '\n' accepted at edge N -> par_input=7 from cycle N+1.
- next_val=1 only in cycle N+2.
- in_ready=1 in cycle N+4.
REQ-025 "4294967296\n" -> par_input=0 (mod 2^32 wrap), err=0; "12a3\n" -> par_input=123, err=1.
REQ-026 "5\r\n":
- with FEEDER_CR_SKIP_EN: par_input=5, err=0.
- without: par_input=5, err=1.
REQ-027 Assert rst during PULSE of "9\n":
- next edge: next_val=0, counts=0, accum=0.
- subsequent "3\n" emits exactly one strobe with par_input=3.
REQ-028 "\n\n\n" -> three strobes of 0 (group_count=3); a 0x04 after DONE produces no strobe and in_ready stays 0.
